// File: rtl/cam_stream_tx.sv
// OV7670-style camera bus transmitter: free-running pclk plus vsync/href/byte framing of
// RGB444 test-pattern frames. Define CAM_STREAM_TX_FRAME_CNT_EN to add the frame_cnt output.
module cam_stream_tx #(
    parameter int unsigned CAM_SCREEN_X = 160,
    parameter int unsigned CAM_SCREEN_Y = 120,
    parameter int unsigned VS_PCLK      = 16,
    parameter int unsigned VBP_PCLK     = 32,
    parameter int unsigned HBLANK_PCLK  = 16,
    parameter int unsigned VFP_PCLK     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        busy,
    output logic        frame_done
`ifdef CAM_STREAM_TX_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);

    localparam logic [15:0] VsLast  = 16'(VS_PCLK - 1);
    localparam logic [15:0] VbpLast = 16'(VBP_PCLK - 1);
    localparam logic [15:0] ActLast = 16'(2 * CAM_SCREEN_X - 1);
    localparam logic [15:0] HbLast  = 16'(HBLANK_PCLK - 1);
    localparam logic [15:0] VfpLast = 16'(VFP_PCLK - 1);
    localparam logic [15:0] YLast   = 16'(CAM_SCREEN_Y - 1);

    typedef enum logic [2:0] {StIdle, StVsync, StVbp, StAct, StHblank, StVfp} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        phase_q, phase_d;
    logic [11:0] idx_q, idx_d;
    logic [1:0]  sel_q, sel_d;
    logic [11:0] color_q, color_d;
    logic        pclk_q;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  fcnt_nib;
    logic [11:0] pix;
    logic [7:0]  y8;
    logic        tick;

`ifdef CAM_STREAM_TX_FRAME_CNT_EN
    logic [7:0] fcnt_q;
    assign fcnt_nib  = fcnt_q[3:0];
    assign frame_cnt = fcnt_q;
`else
    assign fcnt_nib = 4'h0;
`endif

    // Everything except pclk advances only on the clk where pclk is high, so outputs
    // are stable across each pclk rising edge.
    assign tick = pclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= 1'b0;
            idx_q        <= '0;
            sel_q        <= '0;
            color_q      <= '0;
            pclk_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            color_q      <= color_d;
            pclk_q       <= ~pclk_q;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef CAM_STREAM_TX_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else if (frame_done_d) begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        color_d      = color_q;
        frame_done_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_d = StVsync;
                        cnt_d   = '0;
                        sel_d   = pattern_sel;
                        color_d = color;
                    end
                end
                StVsync: begin
                    if (cnt_q == VsLast) begin
                        state_d = StVbp;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StVbp: begin
                    if (cnt_q == VbpLast) begin
                        state_d = StAct;
                        cnt_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                        phase_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StAct: begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        x_d   = x_q + 8'd1;
                        idx_d = idx_q + 12'd1;
                    end
                    if (cnt_q == ActLast) begin
                        state_d = StHblank;
                        cnt_d   = '0;
                        x_d     = '0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StHblank: begin
                    if (cnt_q == HbLast) begin
                        cnt_d = '0;
                        if (y_q < YLast) begin
                            y_d     = y_q + 16'd1;
                            state_d = StAct;
                        end else begin
                            state_d = StVfp;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StVfp: begin
                    if (cnt_q == VfpLast) begin
                        cnt_d        = '0;
                        y_d          = '0;
                        frame_done_d = 1'b1;
                        if (en) begin
                            state_d = StVsync;
                            sel_d   = pattern_sel;
                            color_d = color;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign y8 = y_q[7:0];

    always_comb begin
        pix = '0;
        unique case (sel_q)
            2'd0: pix = color_q;
            2'd1: pix = {x_q[7:4], y8[7:4], x_q[3:0] ^ y8[3:0] ^ fcnt_nib};
            2'd2: pix = idx_q;
            2'd3: pix = (x_q[3] ^ y8[3]) ? 12'hFFF : 12'h000;
            default: pix = '0;
        endcase
    end

    always_comb begin
        CAM_pclk    = pclk_q;
        CAM_vsync   = (state_q == StVsync);
        CAM_href    = (state_q == StAct);
        busy        = (state_q != StIdle);
        frame_done  = frame_done_q;
        CAM_px_data = 8'h00;
        if (state_q == StAct) begin
            CAM_px_data = phase_q ? pix[7:0] : {4'b0000, pix[11:8]};
        end
    end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Self-checking bench for cam_stream_tx: a per-pclk frame model built from the framing and
// pattern rules is compared sample by sample against the DUT outputs.
module tb_cam_stream_tx;

    localparam int X   = 4;
    localparam int Y   = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HB  = 2;
    localparam int VFP = 3;
    localparam int FP  = VS + VBP + Y * (2 * X + HB) + VFP;

`ifdef CAM_STREAM_TX_FRAME_CNT_EN
    localparam logic [3:0] FcMask = 4'hF;
`else
    localparam logic [3:0] FcMask = 4'h0;
`endif

    typedef struct packed {
        logic       v;
        logic       h;
        logic [7:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [11:0] color;
    logic        CAM_pclk;
    logic        CAM_vsync;
    logic        CAM_href;
    logic [7:0]  CAM_px_data;
    logic        busy;
    logic        frame_done;
`ifdef CAM_STREAM_TX_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    cam_stream_tx #(
        .CAM_SCREEN_X (X),
        .CAM_SCREEN_Y (Y),
        .VS_PCLK      (VS),
        .VBP_PCLK     (VBP),
        .HBLANK_PCLK  (HB),
        .VFP_PCLK     (VFP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .color       (color),
        .CAM_pclk    (CAM_pclk),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef CAM_STREAM_TX_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] model_pix(input int sel, input logic [11:0] col,
                                              input int x, input int y, input int fc);
        logic [7:0] xb;
        logic [7:0] yb;
        logic [3:0] fb;
        xb = 8'(x);
        yb = 8'(y);
        fb = 4'(fc) & FcMask;
        case (sel)
            0:       return col;
            1:       return {xb[7:4], yb[7:4], xb[3:0] ^ yb[3:0] ^ fb};
            2:       return 12'((y * X + x) % 4096);
            default: return (xb[3] ^ yb[3]) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    // One entry per pclk period of a whole frame.
    task automatic build_frame(input int sel, input logic [11:0] col, input int fc);
        logic [11:0] p;
        exp_q.delete();
        for (int i = 0; i < VS; i++) exp_q.push_back('{v: 1'b1, h: 1'b0, d: 8'h00});
        for (int i = 0; i < VBP; i++) exp_q.push_back('{v: 1'b0, h: 1'b0, d: 8'h00});
        for (int y = 0; y < Y; y++) begin
            for (int x = 0; x < X; x++) begin
                p = model_pix(sel, col, x, y, fc);
                exp_q.push_back('{v: 1'b0, h: 1'b1, d: {4'h0, p[11:8]}});
                exp_q.push_back('{v: 1'b0, h: 1'b1, d: p[7:0]});
            end
            for (int i = 0; i < HB; i++) exp_q.push_back('{v: 1'b0, h: 1'b0, d: 8'h00});
        end
        for (int i = 0; i < VFP; i++) exp_q.push_back('{v: 1'b0, h: 1'b0, d: 8'h00});
    endtask

    // Checks a frame from the first vsync-high sample; next frame's inputs are applied
    // mid-frame, and en drops at sample drop_k. Returns on the frame_done sample.
    task automatic run_frame(input int sel, input logic [11:0] col, input int fc,
                             input int nsel, input logic [11:0] ncol, input int drop_k);
        int    guard;
        beat_t e;
        guard = 0;
        build_frame(sel, col, fc);
        while (CAM_vsync !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("vsync_start", {15'd0, CAM_vsync}, 16'd1);
        for (int k = 0; k < 2 * FP; k++) begin
            e = exp_q[k / 2];
            chk("vsync", {15'd0, CAM_vsync}, {15'd0, e.v});
            chk("href", {15'd0, CAM_href}, {15'd0, e.h});
            chk("data", {8'd0, CAM_px_data}, {8'd0, e.d});
            chk("busy", {15'd0, busy}, 16'd1);
            if (k > 0) chk("frame_done_low", {15'd0, frame_done}, 16'd0);
`ifdef CAM_STREAM_TX_FRAME_CNT_EN
            if (k == 1) chk("frame_cnt", {8'd0, frame_cnt}, 16'(fc % 256));
`endif
            if (k == 10) begin
                pattern_sel = 2'(nsel);
                color       = ncol;
            end
            if (k == drop_k) en = 1'b0;
            @(negedge clk);
        end
        chk("frame_done_pulse", {15'd0, frame_done}, 16'd1);
        chk("busy_after", {15'd0, busy}, {15'd0, en});
`ifdef CAM_STREAM_TX_FRAME_CNT_EN
        chk("frame_cnt_inc", {8'd0, frame_cnt}, 16'((fc + 1) % 256));
`endif
    endtask

    initial begin
        logic [11:0] c2;
        logic [11:0] c3;
        logic [11:0] c4;
        logic [11:0] c5;
        int          s4;
        logic        prev;

        c2 = 12'($urandom);
        c3 = 12'($urandom);
        c4 = 12'($urandom);
        c5 = 12'($urandom);
        s4 = int'($urandom_range(0, 3));

        rst         = 1'b1;
        en          = 1'b0;
        pattern_sel = 2'd0;
        color       = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pclk", {15'd0, CAM_pclk}, 16'd0);
        chk("rst_vsync", {15'd0, CAM_vsync}, 16'd0);
        chk("rst_href", {15'd0, CAM_href}, 16'd0);
        chk("rst_data", {8'd0, CAM_px_data}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_frame_done", {15'd0, frame_done}, 16'd0);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pclk_after_rst", {15'd0, CAM_pclk}, (i % 2 == 0) ? 16'd1 : 16'd0);
            chk("idle_vsync", {15'd0, CAM_vsync}, 16'd0);
            chk("idle_href", {15'd0, CAM_href}, 16'd0);
            chk("idle_data", {8'd0, CAM_px_data}, 16'd0);
            chk("idle_busy", {15'd0, busy}, 16'd0);
        end

        // Back-to-back frames: solid, index, gradient, random pattern with en dropped mid-line.
        pattern_sel = 2'd0;
        color       = 12'hABC;
        en          = 1'b1;
        run_frame(0, 12'hABC, 0, 2, c2, -1);
        run_frame(2, c2, 1, 1, c3, -1);
        run_frame(1, c3, 2, s4, c4, -1);
        run_frame(s4, c4, 3, 0, 12'h000, 30);

        prev = CAM_pclk;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("idle_pclk_toggle", {15'd0, CAM_pclk}, {15'd0, ~prev});
            prev = CAM_pclk;
            chk("idle_vsync_after", {15'd0, CAM_vsync}, 16'd0);
            chk("idle_busy_after", {15'd0, busy}, 16'd0);
            chk("idle_no_frame_done", {15'd0, frame_done}, 16'd0);
        end

        // Reset in the middle of an active line aborts the frame.
        pattern_sel = 2'd3;
        color       = c5;
        en          = 1'b1;
        begin
            int guard;
            guard = 0;
            while (CAM_vsync !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            chk("abort_vsync_start", {15'd0, CAM_vsync}, 16'd1);
        end
        repeat (14) @(negedge clk);
        chk("abort_in_act", {15'd0, CAM_href}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pclk", {15'd0, CAM_pclk}, 16'd0);
        chk("abort_vsync", {15'd0, CAM_vsync}, 16'd0);
        chk("abort_href", {15'd0, CAM_href}, 16'd0);
        chk("abort_data", {8'd0, CAM_px_data}, 16'd0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_frame_done", {15'd0, frame_done}, 16'd0);
`ifdef CAM_STREAM_TX_FRAME_CNT_EN
        chk("abort_frame_cnt", {8'd0, frame_cnt}, 16'd0);
`endif
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_frame_done", {15'd0, frame_done}, 16'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("fresh_not_vsync_yet", {15'd0, CAM_vsync}, 16'd0);
        run_frame(3, c5, 0, 3, c5, -1);

        en = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
